// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and the default operand width.
package serial_subtractor_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
module serial_subtractor_fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor diff = a - b - bin, LSB first, with valid/ready on both sides.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d, cell_bo;

  serial_subtractor_fs_cell u_fs_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

`ifdef SUB_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = cell_bo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          bout_d  = cell_bo;
`ifdef SUB_OVF_EN
          // On the last bit a_q[0]/b_q[0] are the original operand MSBs.
          ovf_d   = (a_q[0] ^ b_q[0]) & (cell_d ^ a_q[0]);
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed table, handshake corners, exhaustive sweep.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial forever #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the output handshake.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic eb, input int hold);
    int n;
    int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = ia;
    b         = ib;
    bin       = ibin;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    if (n == 50) chk("in_ready_timeout", 0, 1);
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
    lat = 0;
    @(negedge sys_clk);
    while (!out_valid && lat < 3 * W) begin
      @(negedge sys_clk);
      lat++;
    end
    chk("latency", lat, W);
    chk("diff", 32'(diff), 32'(ed));
    chk("bout", 32'(bout), 32'(eb));
    for (int i = 0; i < hold; i++) begin
      @(negedge sys_clk);
      chk("hold_diff", 32'(diff), 32'(ed));
      chk("hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge sys_clk);
    chk("post_hs_valid", 32'(out_valid), 0);
    chk("post_hs_ready", 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    int lat;
    vecs[0]  = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, diff: 4'd6,  bout: 1'b0};
    vecs[1]  = '{a: 4'd3,  b: 4'd9,  bin: 1'b1, diff: 4'd9,  bout: 1'b1};
    vecs[2]  = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, diff: 4'd15, bout: 1'b1};
    vecs[3]  = '{a: 4'd15, b: 4'd15, bin: 1'b0, diff: 4'd0,  bout: 1'b0};
    vecs[4]  = '{a: 4'd15, b: 4'd0,  bin: 1'b0, diff: 4'd15, bout: 1'b0};
    vecs[5]  = '{a: 4'd7,  b: 4'd2,  bin: 1'b0, diff: 4'd5,  bout: 1'b0};
    vecs[6]  = '{a: 4'd2,  b: 4'd5,  bin: 1'b0, diff: 4'd13, bout: 1'b1};
    vecs[7]  = '{a: 4'd10, b: 4'd10, bin: 1'b1, diff: 4'd15, bout: 1'b1};
    vecs[8]  = '{a: 4'd6,  b: 4'd5,  bin: 1'b1, diff: 4'd0,  bout: 1'b0};
    vecs[9]  = '{a: 4'd8,  b: 4'd1,  bin: 1'b0, diff: 4'd7,  bout: 1'b0};
    vecs[10] = '{a: 4'd5,  b: 4'd2,  bin: 1'b0, diff: 4'd3,  bout: 1'b0};

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_bout", 32'(bout), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, i % 3);
`ifdef SUB_OVF_EN
      if (i == 9) chk("ovf_8_1", 32'(ovf), 1);
      if (i == 10) chk("ovf_5_2", 32'(ovf), 0);
`endif
    end

    // Stall in DONE with new operands presented
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 4'd12; b = 4'd4; bin = 1'b0;
    @(posedge sys_clk);
    #1 a = 4'd1; b = 4'd0;
    lat = 0;
    @(negedge sys_clk);
    while (!out_valid && lat < 3 * W) begin
      @(negedge sys_clk);
      lat++;
    end
    chk("stall_latency", lat, W);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("stall_diff", 32'(diff), 8);
      chk("stall_bout", 32'(bout), 0);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge sys_clk);
    chk("stall_hs_valid", 32'(out_valid), 0);
    chk("stall_hs_in_ready", 32'(in_ready), 1);
    chk("stall_hs_diff", 32'(diff), 8);
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
    lat = 0;
    @(negedge sys_clk);
    while (!out_valid && lat < 3 * W) begin
      @(negedge sys_clk);
      lat++;
    end
    chk("next_latency", lat, W);
    chk("next_diff", 32'(diff), 1);
    chk("next_bout", 32'(bout), 0);
    @(negedge sys_clk);
    out_ready = 1'b0;

    // Asynchronous reset mid-RUN
    in_valid = 1'b1;
    a = 4'd9; b = 4'd3; bin = 1'b0;
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_diff", 32'(diff), 0);
    chk("arst_bout", 32'(bout), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    do_op(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 0);

    // Exhaustive sweep against an arithmetic model
    for (int i = 0; i < 512; i++) begin
      logic [W-1:0] ea, eb;
      logic         ebin;
      logic [4:0]   full;
      ea   = W'(i >> 5);
      eb   = W'(i >> 1);
      ebin = 1'(i);
      full = {1'b0, ea} - {1'b0, eb} - {4'b0, ebin};
      do_op(ea, eb, ebin, full[W-1:0], ({1'b0, ea} < ({1'b0, eb} + {4'b0, ebin})),
            int'($urandom_range(0, 2)));
`ifdef SUB_OVF_EN
      chk("sweep_ovf", 32'(ovf), 32'((ea[W-1] != eb[W-1]) && (full[W-1] != ea[W-1])));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
